// File: rtl/vedic_pkg.sv
// Shared definitions for the iterative Vedic multiplier.
//
// Contents:
//   - FSM state encoding (IDLE / RUN / DONE) as localparam constants and enum
//   - default operand width, digit count D, pair count P and counter width
//   - pair_issued(): whether a digit pair is sent to the 2x2 core
//   - first_idx(): first pair index issued after an accept
//
// Build option:
//   VEDIC_APPROX_EN - when defined, the three lowest-weight digit pairs
//                     (i+j < 2) are never issued, trading accuracy
//                     (error <= 81 for N=8) for three fewer cycles.
package vedic_pkg;

  localparam int VEDIC_N = 8;
  localparam int D       = VEDIC_N / 2;
  localparam int CNT_W   = $clog2(D * D);

`ifdef VEDIC_APPROX_EN
  localparam bit APPROX_EN = 1'b1;
  localparam int P         = D * D - 3;
`else
  localparam bit APPROX_EN = 1'b0;
  localparam int P         = D * D;
`endif

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    RUN  = ST_RUN,
    DONE = ST_DONE
  } state_e;

  // Pair index k maps to digit i = k mod d of a and digit j = k div d of b.
  function automatic logic pair_issued(input int k, input int d);
    logic skip;
    skip = ((k % d) + (k / d)) < 2;
    return !(APPROX_EN && skip);
  endfunction

  // Approximate mode starts past (0,0) and (1,0); for d == 2 index 2 is
  // (0,1), also skipped, so the only issued pair is index 3.
  function automatic int first_idx(input int d);
    if (!APPROX_EN) return 0;
    return (d == 2) ? 3 : 2;
  endfunction

endpackage

// File: rtl/vedic_2x2.sv
// Combinational 2-bit x 2-bit Vedic (Urdhva-Tiryagbhyam) multiplier.
//
// Ports:
//   i_a [1:0] - multiplicand digit
//   i_b [1:0] - multiplier digit
//   o_p [3:0] - unsigned product i_a * i_b
module vedic_2x2 (
  input  logic [1:0] i_a,
  input  logic [1:0] i_b,
  output logic [3:0] o_p
);

  logic w_cross_lo;
  logic w_cross_hi;
  logic w_vert_hi;
  logic w_carry;

  assign w_cross_lo = i_a[1] & i_b[0];
  assign w_cross_hi = i_a[0] & i_b[1];
  assign w_vert_hi  = i_a[1] & i_b[1];
  assign w_carry    = w_cross_lo & w_cross_hi;

  assign o_p[0] = i_a[0] & i_b[0];
  assign o_p[1] = w_cross_lo ^ w_cross_hi;
  assign o_p[2] = w_vert_hi ^ w_carry;
  assign o_p[3] = w_vert_hi & w_carry;

endmodule

// File: rtl/vedic_seq_mult.sv
// Iterative N x N unsigned multiplier built around one vedic_2x2 core.
// Both operands are split into D = N/2 two-bit digits; one digit pair is
// multiplied per cycle and the 4-bit partial product is shifted by its
// digit weight 2*(i+j) and accumulated into a 2N-bit register.
//
// Ports:
//   clk         - rising-edge clock
//   rst_n       - asynchronous active-low reset
//   in_valid    - operand pair valid
//   in_ready    - block can accept operands (IDLE only)
//   a, b [N-1:0]- unsigned operands
//   out_valid   - product valid (DONE)
//   out_ready   - consumer accepts product
//   product     - 2N-bit unsigned result (accumulator)
//   busy        - high in RUN or DONE
//   o_dbg_state - current FSM state (ST_IDLE / ST_RUN / ST_DONE)
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; valid sources hold their data stable until that edge.
//
// Build option: VEDIC_APPROX_EN skips the three lowest-weight digit pairs.
module vedic_seq_mult
  import vedic_pkg::*;
#(
  parameter int N = VEDIC_N
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] product,
  output logic           busy,
  output logic [1:0]     o_dbg_state
);

  localparam int DL = N / 2;
  localparam int PP = DL * DL;
  localparam int CW = $clog2(PP);
  localparam logic [CW-1:0] IDX_FIRST = CW'(first_idx(DL));
  localparam logic [CW-1:0] IDX_LAST  = CW'(PP - 1);

  logic [1:0]     r_state;
  logic [N-1:0]   r_a;
  logic [N-1:0]   r_b;
  logic [2*N-1:0] r_acc;
  logic [CW-1:0]  r_idx;

  int             w_i;
  int             w_j;
  logic [1:0]     w_a_dig;
  logic [1:0]     w_b_dig;
  logic [3:0]     w_pp;
  logic [2*N-1:0] w_pp_shift;
  logic [CW-1:0]  w_idx_next;

  // Digit selection and weighting of the core output.
  always_comb begin
    w_i        = int'(r_idx) % DL;
    w_j        = int'(r_idx) / DL;
    w_a_dig    = 2'(r_a >> (2 * w_i));
    w_b_dig    = 2'(r_b >> (2 * w_j));
    w_pp_shift = (2 * N)'(w_pp) << (2 * (w_i + w_j));
  end

  // After the start index, at most one skipped pair (index D) can follow,
  // so stepping by two past a skipped slot is sufficient.
  always_comb begin
    w_idx_next = r_idx + CW'(1);
    if (!pair_issued(int'(w_idx_next), DL)) begin
      w_idx_next = r_idx + CW'(2);
    end
  end

  vedic_2x2 u_core (
    .i_a (w_a_dig),
    .i_b (w_b_dig),
    .o_p (w_pp)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_idx   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_a     <= a;
            r_b     <= b;
            r_acc   <= '0;
            r_idx   <= IDX_FIRST;
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          r_acc <= r_acc + w_pp_shift;
          if (r_idx == IDX_LAST) begin
            r_state <= ST_DONE;
          end else begin
            r_idx <= w_idx_next;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready    = (r_state == ST_IDLE);
  assign out_valid   = (r_state == ST_DONE);
  assign busy        = (r_state == ST_RUN) || (r_state == ST_DONE);
  assign product     = r_acc;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_vedic_seq_mult.sv
// Self-checking bench for vedic_seq_mult (N = 8), exact or VEDIC_APPROX_EN.
module tb_vedic_seq_mult;

`ifdef VEDIC_APPROX_EN
  localparam int P_EXP = 13;
`else
  localparam int P_EXP = 16;
`endif
  localparam int TMO = 100;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] product;
  logic        busy;
  logic [1:0]  dbg_state;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  vedic_seq_mult #(.N(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .a           (a),
    .b           (b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .product     (product),
    .busy        (busy),
    .o_dbg_state (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;
  logic [15:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Reference: true product, minus the dropped low-weight digit products
  // when the approximate build is selected.
  function automatic logic [15:0] model(input logic [7:0] x, input logic [7:0] y);
    int e;
    e = int'(x) * int'(y);
`ifdef VEDIC_APPROX_EN
    begin
      int x0, x1, y0, y1;
      x0 = int'(x) % 4;
      x1 = (int'(x) / 4) % 4;
      y0 = int'(y) % 4;
      y1 = (int'(y) / 4) % 4;
      e = e - (x0 * y0 + 4 * (x1 * y0 + x0 * y1));
    end
`endif
    return 16'(e);
  endfunction

  // ---------------- driver ----------------
  // Entered at a negedge. Offers operands, waits for the accept edge,
  // then counts cycles until out_valid. Returns at the negedge where
  // out_valid is first seen high.
  task automatic run_op(input logic [7:0] ia, input logic [7:0] ib,
                        output logic [15:0] prod, output int lat, output int acc_cyc);
    int w;
    in_valid = 1'b1;
    a = ia;
    b = ib;
    w = 0;
    while (!in_ready && w < TMO) begin
      @(negedge clk);
      w++;
    end
    check("accept_timeout", 32'(w < TMO), 32'd1);
    acc_cyc = cyc;
    @(negedge clk);
    in_valid = 1'b0;
    a = $urandom_range(0, 255);
    b = $urandom_range(0, 255);
    lat = 0;
    while (!out_valid && lat < TMO) begin
      @(negedge clk);
      lat++;
    end
    prod = product;
  endtask

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] exp_p;
  } vec_t;

  vec_t        tbl[3];
  logic [15:0] prod;
  logic [15:0] held;
  int          lat;
  int          acc_cyc;
  int          prev_acc;

  initial begin
`ifdef VEDIC_APPROX_EN
    tbl[0] = '{a: 8'd255, b: 8'd255, exp_p: 16'd64944};
    tbl[1] = '{a: 8'd3,   b: 8'd3,   exp_p: 16'd0};
    tbl[2] = '{a: 8'd12,  b: 8'd12,  exp_p: 16'd144};
`else
    tbl[0] = '{a: 8'd255, b: 8'd255, exp_p: 16'd65025};
    tbl[1] = '{a: 8'd0,   b: 8'd171, exp_p: 16'd0};
    tbl[2] = '{a: 8'd13,  b: 8'd200, exp_p: 16'd2600};
`endif

    // ---- reset ----
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a         = 8'd0;
    b         = 8'd0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_product", 32'(product), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("post_rst_in_ready", 32'(in_ready), 32'd1);
    check("post_rst_busy", 32'(busy), 32'd0);

    // ---- directed table ----
    for (int i = 0; i < 3; i++) begin
      run_op(tbl[i].a, tbl[i].b, prod, lat, acc_cyc);
      check($sformatf("tbl%0d_product", i), 32'(prod), 32'(tbl[i].exp_p));
      check($sformatf("tbl%0d_latency", i), 32'(lat), 32'(P_EXP));
    end

    // ---- back-pressure ----
    @(negedge clk);
    out_ready = 1'b0;
    run_op(8'd77, 8'd91, prod, lat, acc_cyc);
    check("bp_product", 32'(prod), 32'(model(8'd77, 8'd91)));
    held     = product;
    in_valid = 1'b1;
    a        = 8'd5;
    b        = 8'd6;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_hold_product", 32'(product), 32'(held));
      check("bp_hold_valid", 32'(out_valid), 32'd1);
      check("bp_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_valid", 32'(out_valid), 32'd0);
    check("bp_release_in_ready", 32'(in_ready), 32'd1);
    run_op(8'd5, 8'd6, prod, lat, acc_cyc);
    check("bp_next_product", 32'(prod), 32'(model(8'd5, 8'd6)));
    check("bp_next_latency", 32'(lat), 32'(P_EXP));

    // ---- reset mid-RUN ----
    @(negedge clk);
    in_valid = 1'b1;
    a        = 8'd200;
    b        = 8'd100;
    begin
      int w;
      w = 0;
      while (!in_ready && w < TMO) begin
        @(negedge clk);
        w++;
      end
      check("mid_accept_timeout", 32'(w < TMO), 32'd1);
    end
    @(negedge clk);
    in_valid = 1'b0;
    repeat (6) @(negedge clk);
    check("mid_busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_product", 32'(product), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op(8'd200, 8'd100, prod, lat, acc_cyc);
    check("mid_next_product", 32'(prod), 32'(model(8'd200, 8'd100)));

    // ---- back-to-back random ----
    prev_acc = 0;
    for (int i = 0; i < 16; i++) begin
      logic [7:0] ra;
      logic [7:0] rb;
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      exp_q.push_back(model(ra, rb));
      run_op(ra, rb, prod, lat, acc_cyc);
      check($sformatf("rnd%0d_product", i), 32'(prod), 32'(exp_q.pop_front()));
      check($sformatf("rnd%0d_latency", i), 32'(lat), 32'(P_EXP));
      if (i > 0) begin
        check($sformatf("rnd%0d_spacing", i), 32'(acc_cyc - prev_acc), 32'(P_EXP + 2));
      end
      prev_acc = acc_cyc;
    end

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
